// File: rtl/prio_intc.sv
// Clocked interrupt-priority controller: edge capture into sticky pending bits, fixed group priority,
// valid/ready presentation. Define PRIO_INTC_ROTATE_EN for round-robin priority within each group.
module prio_intc #(
    parameter int CHANNELS = 9,
    parameter int GROUPS   = 3,
    parameter int CH_W     = $clog2(CHANNELS),
    parameter int GR_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [GROUPS*CHANNELS-1:0]   req,
    input  logic [CHANNELS-1:0]          mask,
    output logic                         irq_valid,
    output logic [GR_W-1:0]              irq_grp,
    output logic [CH_W-1:0]              irq_chan,
    input  logic                         irq_ready,
    output logic [GROUPS-1:0]            grp_active,
    output logic [7:0]                   drop_cnt
);

    localparam int N = GROUPS * CHANNELS;

    typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;

    state_t            state, state_next;
    logic [N-1:0]      req_q, pend, pend_next, edges, eligible, clr, mask_all;
    logic [GROUPS-1:0] grp_any;
    logic              any_eligible, handshake, load_win;
    logic [GR_W-1:0]   win_grp;
    logic [CH_W-1:0]   win_chan;
    logic [7:0]        drop_next;
    int                drop_sum;

`ifdef PRIO_INTC_ROTATE_EN
    logic [CH_W-1:0]   ptr [GROUPS];
`endif

    always_comb begin
        mask_all = '0;
        grp_any  = '0;
        for (int g = 0; g < GROUPS; g++) begin
            mask_all[g*CHANNELS +: CHANNELS] = mask;
            grp_any[g] = |(pend[g*CHANNELS +: CHANNELS] & mask);
        end
    end

    assign edges        = req & ~req_q & mask_all;
    assign eligible     = pend & mask_all;
    assign any_eligible = |eligible;
    assign handshake    = (state == PRESENT) && irq_ready;

    // The presented source is cleared on handshake; a coincident edge re-arms it without a drop.
    always_comb begin
        clr = '0;
        for (int s = 0; s < N; s++) begin
            if (handshake && (s == int'(irq_grp) * CHANNELS + int'(irq_chan)))
                clr[s] = 1'b1;
        end
    end

    assign pend_next = (pend & ~clr) | edges;

    always_comb begin
        drop_sum = int'(drop_cnt);
        for (int s = 0; s < N; s++) begin
            if (edges[s] && pend[s] && !clr[s])
                drop_sum = drop_sum + 1;
        end
        drop_next = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
    end

    // Lowest eligible group wins; the channel search order depends on the rotate build option.
    always_comb begin
        logic found, cfound;
        int   idx;
        found    = 1'b0;
        cfound   = 1'b0;
        idx      = 0;
        win_grp  = '0;
        win_chan = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (!found && grp_any[g]) begin
                found   = 1'b1;
                win_grp = GR_W'(g);
                for (int k = 0; k < CHANNELS; k++) begin
`ifdef PRIO_INTC_ROTATE_EN
                    idx = (int'(ptr[g]) + 1 + k) % CHANNELS;
`else
                    idx = k;
`endif
                    if (!cfound && eligible[g*CHANNELS + idx]) begin
                        cfound   = 1'b1;
                        win_chan = CH_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        load_win   = 1'b0;
        case (state)
            IDLE: begin
                if (any_eligible)
                    state_next = ARB;
            end
            ARB: begin
                if (any_eligible) begin
                    load_win   = 1'b1;
                    state_next = PRESENT;
                end else begin
                    state_next = IDLE;
                end
            end
            PRESENT: begin
                if (irq_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // req_q tracks req even in reset so lines already high never look like fresh edges.
    always_ff @(posedge CLK) begin
        req_q <= req;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            pend       <= '0;
            irq_valid  <= 1'b0;
            irq_grp    <= '0;
            irq_chan   <= '0;
            grp_active <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_next;
            pend       <= pend_next;
            grp_active <= grp_any;
            drop_cnt   <= drop_next;
            if (load_win) begin
                irq_valid <= 1'b1;
                irq_grp   <= win_grp;
                irq_chan  <= win_chan;
            end else if (handshake) begin
                irq_valid <= 1'b0;
            end
        end
    end

`ifdef PRIO_INTC_ROTATE_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int g = 0; g < GROUPS; g++)
                ptr[g] <= CH_W'(CHANNELS - 1);
        end else begin
            for (int g = 0; g < GROUPS; g++) begin
                if (handshake && (irq_grp == GR_W'(g)))
                    ptr[g] <= irq_chan;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prio_intc.sv
// Self-checking bench for prio_intc (default build): cycle model compared every clock,
// plus directed literal expectations for the documented scenarios.
module tb_prio_intc;

    localparam int CH = 9;
    localparam int GR = 3;
    localparam int N  = CH * GR;

    logic          CLK = 1'b0;
    logic          RST;
    logic [N-1:0]  req;
    logic [CH-1:0] mask;
    logic          irq_ready;
    logic          irq_valid;
    logic [1:0]    irq_grp;
    logic [3:0]    irq_chan;
    logic [GR-1:0] grp_active;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  m_pend, m_reqq;
    logic [GR-1:0] m_gact;
    logic          m_valid;
    int            m_phase, m_grp, m_chan, m_drop;

    prio_intc dut (
        .CLK(CLK), .RST(RST), .req(req), .mask(mask),
        .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_chan(irq_chan),
        .irq_ready(irq_ready), .grp_active(grp_active), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [CH-1:0] m, input logic rdy);
        req       = r;
        mask      = m;
        irq_ready = rdy;
    endtask

    // Model: winner is simply the lowest flat index among enabled pending sources.
    task automatic modelStep();
        int   first, hidx;
        logic hs, e, c;
        if (RST) begin
            m_pend  = '0;
            m_reqq  = req;
            m_gact  = '0;
            m_valid = 1'b0;
            m_phase = 0;
            m_grp   = 0;
            m_chan  = 0;
            m_drop  = 0;
        end else begin
            hs    = m_valid && irq_ready;
            hidx  = m_grp * CH + m_chan;
            first = -1;
            m_gact = '0;
            for (int s = N - 1; s >= 0; s--) begin
                if (m_pend[s] && mask[s % CH]) begin
                    first = s;
                    m_gact[s / CH] = 1'b1;
                end
            end
            case (m_phase)
                0: if (first >= 0) m_phase = 1;
                1: begin
                    if (first >= 0) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                        m_grp   = first / CH;
                        m_chan  = first % CH;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: begin
                    if (irq_ready) begin
                        m_phase = 0;
                        m_valid = 1'b0;
                    end
                end
            endcase
            for (int s = 0; s < N; s++) begin
                e = req[s] && !m_reqq[s] && mask[s % CH];
                c = hs && (s == hidx);
                if (e && m_pend[s] && !c && m_drop < 255)
                    m_drop++;
                m_pend[s] = (m_pend[s] && !c) || e;
            end
            m_reqq = req;
        end
    endtask

    task automatic compareModel();
        checkOutput("model_valid", int'(irq_valid), int'(m_valid));
        checkOutput("model_grp", int'(irq_grp), m_grp);
        checkOutput("model_chan", int'(irq_chan), m_chan);
        checkOutput("model_grp_active", int'(grp_active), int'(m_gact));
        checkOutput("model_drop_cnt", int'(drop_cnt), m_drop);
        checkOutput("grp_range", int'(irq_grp < 2'(GR)), 1);
        checkOutput("chan_range", int'(irq_chan < 4'(CH)), 1);
    endtask

    task automatic tick();
        @(posedge CLK);
        modelStep();
        #1;
        compareModel();
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!irq_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("valid_timeout", int'(irq_valid), 1);
    endtask

    task automatic accept();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
    endtask

    task automatic pulse(input int s);
        req[s] = 1'b1;
        tick();
        req[s] = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int eg[3];
        int ec[3];
        eg = '{0, 0, 2};
        ec = '{3, 7, 2};

        RST = 1'b1;
        applyStimulus('0, '1, 1'b0);
        repeat (3) tick();
        RST = 1'b0;
        tick();
        checkOutput("reset_valid", int'(irq_valid), 0);
        checkOutput("reset_grp_active", int'(grp_active), 0);
        checkOutput("reset_drop", int'(drop_cnt), 0);

        // Single source, held presentation
        req[13] = 1'b1;
        tick();
        req[13] = 1'b0;
        tick();
        checkOutput("t1_valid_k1", int'(irq_valid), 0);
        checkOutput("t1_grp_active_k1", int'(grp_active), 2);
        tick();
        checkOutput("t1_valid_k2", int'(irq_valid), 1);
        checkOutput("t1_grp", int'(irq_grp), 1);
        checkOutput("t1_chan", int'(irq_chan), 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t1_hold_valid", int'(irq_valid), 1);
            checkOutput("t1_hold_grp", int'(irq_grp), 1);
            checkOutput("t1_hold_chan", int'(irq_chan), 4);
        end
        accept();
        checkOutput("t1_valid_after_hs", int'(irq_valid), 0);
        tick();
        checkOutput("t1_grp_active_clear", int'(grp_active), 0);

        // Simultaneous sources served in priority order
        req[20] = 1'b1; req[7] = 1'b1; req[3] = 1'b1;
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            waitValid(n);
            checkOutput("t2_spacing", n, 2);
            checkOutput("t2_grp", int'(irq_grp), eg[i]);
            checkOutput("t2_chan", int'(irq_chan), ec[i]);
            accept();
        end

        // Masked edges are neither captured nor counted
        mask[5] = 1'b0;
        pulse(5);
        pulse(14);
        mask = '1;
        repeat (6) tick();
        checkOutput("t3_valid", int'(irq_valid), 0);
        checkOutput("t3_drop", int'(drop_cnt), 0);
        checkOutput("t3_grp_active", int'(grp_active), 0);

        // Masking a pending source hides it until re-enabled
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        mask[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t3_hidden_valid", int'(irq_valid), 0);
        end
        checkOutput("t3_hidden_grp_active", int'(grp_active), 0);
        mask[2] = 1'b1;
        waitValid(n);
        checkOutput("t3_unmask_grp", int'(irq_grp), 0);
        checkOutput("t3_unmask_chan", int'(irq_chan), 2);
        accept();

        // Edge coincident with handshake re-arms without a drop
        pulse(0);
        waitValid(n);
        checkOutput("t4_first_chan", int'(irq_chan), 0);
        req[0] = 1'b1;
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        req[0] = 1'b0;
        checkOutput("t4_coincident_drop", int'(drop_cnt), 0);
        checkOutput("t4_coincident_valid", int'(irq_valid), 0);
        waitValid(n);
        checkOutput("t4_second_grp", int'(irq_grp), 0);
        checkOutput("t4_second_chan", int'(irq_chan), 0);

        // Drop counter saturation while presentation is held
        for (int i = 0; i < 300; i++)
            pulse(0);
        checkOutput("t4_drop_sat", int'(drop_cnt), 255);
        checkOutput("t4_held_valid", int'(irq_valid), 1);
        accept();
        checkOutput("t4_valid_after_hs", int'(irq_valid), 0);

        // Reset during presentation with all lines high
        pulse(1);
        waitValid(n);
        checkOutput("t5_pre_chan", int'(irq_chan), 1);
        req = '1;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checkOutput("t5_valid", int'(irq_valid), 0);
        checkOutput("t5_grp", int'(irq_grp), 0);
        checkOutput("t5_chan", int'(irq_chan), 0);
        checkOutput("t5_grp_active", int'(grp_active), 0);
        checkOutput("t5_drop", int'(drop_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("t5_no_present", int'(irq_valid), 0);
        end
        req = '0;
        tick();
        pulse(9);
        waitValid(n);
        checkOutput("t5_new_grp", int'(irq_grp), 1);
        checkOutput("t5_new_chan", int'(irq_chan), 0);
        accept();

        // Fixed within-group priority: channel 1 wins whenever it is pending
        req[1] = 1'b1; req[4] = 1'b1; req[8] = 1'b1;
        tick();
        req = '0;
        for (int r = 0; r < 3; r++) begin
            waitValid(n);
            checkOutput("t6_fixed_chan1", int'(irq_chan), 1);
            accept();
            if (r < 2) begin
                req[1] = 1'b1;
                tick();
                req[1] = 1'b0;
            end
        end
        waitValid(n);
        checkOutput("t6_fixed_chan4", int'(irq_chan), 4);
        accept();
        waitValid(n);
        checkOutput("t6_fixed_chan8", int'(irq_chan), 8);
        accept();
        repeat (4) tick();
        checkOutput("t6_idle_valid", int'(irq_valid), 0);
        checkOutput("t6_idle_grp_active", int'(grp_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
